downtimer: RTL and testbench

- Programmable down-counting interval timer; the generate-side companion to the free-running upcounter used for elapsed-time measurement.
- Loads a reload value, counts down on prescaled ticks, and emits a one-cycle terminal-count pulse.
- Supports one-shot or auto-reload operation.
- Drives timeouts, mute-delay sequencing and periodic service strobes in the digital audio control path.

---
 rtl/downtimer_pkg.sv | 21 ++
 rtl/downtimer_if.sv | 38 +++
 rtl/downtimer_prescaler.sv | 37 +++
 rtl/downtimer.sv | 119 +++++++++++
 tb/tb_downtimer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/downtimer_pkg.sv
// Shared types and constants for the downtimer interval timer.
// Optional build macro DOWNTIMER_TC_COUNT_EN enables the terminal-count tally width below.
package downtimer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic ModeOneshot = 1'b0;
  localparam logic ModeReload  = 1'b1;

  localparam int unsigned TcCntWidth = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TcCntWidth-1:0] sat_inc(input logic [TcCntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/downtimer_if.sv
// Control/status bundle for the downtimer; master drives controls, slave is the timer.
// Carries tc_cnt_o only when DOWNTIMER_TC_COUNT_EN is defined.
interface downtimer_if #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned PRE_WIDTH = 4
);
  import downtimer_pkg::*;

  logic                 load_i;
  logic [WIDTH-1:0]     dat_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 mode_i;
  logic [PRE_WIDTH-1:0] pre_i;
  logic [WIDTH-1:0]     cnt_o;
  logic                 tc_o;
  logic                 busy_o;
`ifdef DOWNTIMER_TC_COUNT_EN
  logic [TcCntWidth-1:0] tc_cnt_o;
`endif

  modport master (
    output load_i, dat_i, start_i, stop_i, mode_i, pre_i,
`ifdef DOWNTIMER_TC_COUNT_EN
    input  tc_cnt_o,
`endif
    input  cnt_o, tc_o, busy_o
  );

  modport slave (
    input  load_i, dat_i, start_i, stop_i, mode_i, pre_i,
`ifdef DOWNTIMER_TC_COUNT_EN
    output tc_cnt_o,
`endif
    output cnt_o, tc_o, busy_o
  );

endinterface

// File: rtl/downtimer_prescaler.sv
// Prescaler for the downtimer: counts 0..pre_i while enabled and flags a tick at the top.
module downtimer_prescaler #(
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [PRE_WIDTH-1:0] pre_i,
  output logic                 tick_o
);

  logic [PRE_WIDTH-1:0] cnt_q, cnt_d;

  // >= rather than == so a divisor lowered below the current count still wraps.
  assign tick_o = en_i && (cnt_q >= pre_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/downtimer.sv
// Programmable down-counting interval timer with one-shot / auto-reload and a registered
// terminal-count pulse. Define DOWNTIMER_TC_COUNT_EN to add the saturating tc_cnt_o tally.
module downtimer
  import downtimer_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        clr_i,
  downtimer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rel_q;
  logic             tc_q, tc_d;
  logic             pre_en, pre_clear, tick;
  logic             launch;

  // Stop outranks start everywhere, including IDLE.
  assign launch    = (state_q == StIdle) && bus.start_i && !bus.stop_i;
  assign pre_en    = (state_q == StRun) && !bus.stop_i;
  assign pre_clear = launch;

  downtimer_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk_i   (clk_i),
    .clr_i   (clr_i),
    .en_i    (pre_en),
    .clear_i (pre_clear),
    .pre_i   (bus.pre_i),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StRun;
          cnt_d   = bus.load_i ? bus.dat_i : rel_q;
        end
      end
      StRun: begin
        if (bus.stop_i) begin
          state_d = StHold;
        end else if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (bus.mode_i == ModeReload) begin
              cnt_d = rel_q;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StHold: begin
        if (bus.stop_i) begin
          state_d = StIdle;
        end else if (bus.start_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rel_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      if (bus.load_i) begin
        rel_q <= bus.dat_i;
      end
    end
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.tc_o   = tc_q;
  assign bus.busy_o = (state_q != StIdle);

`ifdef DOWNTIMER_TC_COUNT_EN
  logic [TcCntWidth-1:0] tc_cnt_q, tc_cnt_d;

  // Counts on tc_d so the tally moves in the same cycle tc_o rises.
  always_comb begin
    tc_cnt_d = tc_cnt_q;
    if (launch) begin
      tc_cnt_d = '0;
    end else if (tc_d) begin
      tc_cnt_d = sat_inc(tc_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      tc_cnt_q <= '0;
    end else begin
      tc_cnt_q <= tc_cnt_d;
    end
  end

  assign bus.tc_cnt_o = tc_cnt_q;
`endif

endmodule

// File: tb/tb_downtimer.sv
// Bench for downtimer: directed scenarios plus random traffic against a behavioural model.
module tb_downtimer;

  localparam int unsigned W  = 10;
  localparam int unsigned PW = 4;

  logic clk;
  logic clr;

  downtimer_if #(.WIDTH(W), .PRE_WIDTH(PW)) bus ();

  downtimer #(
    .WIDTH     (W),
    .PRE_WIDTH (PW)
  ) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer as "busy / paused" flags, a plain integer count, and a
  // clocks-since-last-tick counter.
  bit m_busy, m_paused, m_tc;
  int m_cnt, m_rel, m_since, m_tcn;

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_tc = 0;
    m_cnt = 0; m_rel = 0; m_since = 0; m_tcn = 0;
  endtask

  task automatic model_step();
    bit ld = bus.load_i, st = bus.start_i, sp = bus.stop_i, md = bus.mode_i;
    int d = int'(bus.dat_i);
    int p = int'(bus.pre_i);
    bit fire = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        m_cnt = ld ? d : m_rel;
        m_since = 0; m_busy = 1; m_paused = 0; m_tcn = 0;
      end
    end else if (m_paused) begin
      if (sp) m_busy = 0;
      else if (st) m_paused = 0;
    end else if (sp) begin
      m_paused = 1;
    end else if (m_since < p) begin
      m_since++;
    end else begin
      m_since = 0;
      if (m_cnt > 0) begin
        m_cnt--;
      end else begin
        fire = 1;
        if (md) m_cnt = m_rel;
        else m_busy = 0;
      end
    end
    if (ld) m_rel = d;
    m_tc = fire;
    if (fire && m_tcn < 255) m_tcn++;
  endtask

  // One clock: model advances at the edge, DUT compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (clr) model_reset();
    else model_step();
    #1;
    check_eq("cnt", 32'(bus.cnt_o), 32'(m_cnt));
    check_eq("tc", 32'(bus.tc_o), 32'(m_tc));
    check_eq("busy", 32'(bus.busy_o), 32'(m_busy));
`ifdef DOWNTIMER_TC_COUNT_EN
    check_eq("tc_cnt", 32'(bus.tc_cnt_o), 32'(m_tcn));
`endif
  endtask

  task automatic load_val(input int v);
    bus.load_i = 1'b1;
    bus.dat_i  = W'(v);
    cycle();
    bus.load_i = 1'b0;
  endtask

  task automatic stop_to_idle();
    bus.stop_i = 1'b1;
    cycle();
    cycle();
    bus.stop_i = 1'b0;
  endtask

  int tcq[$];
  int cq[$];
  int first;

  initial begin
    clr = 1'b1;
    bus.load_i = 1'b0; bus.dat_i = '0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    bus.mode_i = 1'b0; bus.pre_i = '0;
    model_reset();
    #2;
    check_eq("rst_cnt", 32'(bus.cnt_o), 32'd0);
    check_eq("rst_tc", 32'(bus.tc_o), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // One-shot R=3 P=0.
    bus.mode_i = 1'b0; bus.pre_i = 4'd0;
    load_val(3);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    check_eq("os_cnt0", 32'(bus.cnt_o), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_eq("os_cnt", 32'(bus.cnt_o), 32'(3 - i));
    end
    cycle();
    check_eq("os_tc", 32'(bus.tc_o), 32'd1);
    check_eq("os_busy", 32'(bus.busy_o), 32'd0);
    cycle();
    check_eq("os_tc_off", 32'(bus.tc_o), 32'd0);

    // Auto-reload R=2 P=1: tc every 6 clocks.
    bus.mode_i = 1'b1; bus.pre_i = 4'd1;
    load_val(2);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    tcq.delete();
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (bus.tc_o) begin
        tcq.push_back(k);
        check_eq("ar_reload", 32'(bus.cnt_o), 32'd2);
      end
    end
    check_eq("ar_npulse", 32'(tcq.size()), 32'd5);
    for (int i = 0; i < tcq.size(); i++) check_eq("ar_edge", 32'(tcq[i]), 32'(6 * (i + 1)));
    stop_to_idle();

    // Stop / resume R=5 P=0 one-shot.
    bus.mode_i = 1'b0; bus.pre_i = 4'd0;
    load_val(5);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    cycle();
    cycle();
    check_eq("sr_pre", 32'(bus.cnt_o), 32'd3);
    bus.stop_i = 1'b1;
    cycle();
    bus.stop_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("sr_hold", 32'(bus.cnt_o), 32'd3);
      check_eq("sr_busy", 32'(bus.busy_o), 32'd1);
    end
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (bus.tc_o && first < 0) first = k;
    end
    check_eq("sr_tc", 32'(first), 32'd4);

    // Load 7 while auto-reloading from 2.
    bus.mode_i = 1'b1; bus.pre_i = 4'd0;
    load_val(2);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    load_val(7);
    tcq.delete(); cq.delete();
    for (int k = 2; k <= 14; k++) begin
      cycle();
      if (bus.tc_o) begin
        tcq.push_back(k);
        cq.push_back(int'(bus.cnt_o));
      end
    end
    check_eq("ld_npulse", 32'(tcq.size()), 32'd2);
    if (tcq.size() >= 2) begin
      check_eq("ld_first", 32'(tcq[0]), 32'd3);
      check_eq("ld_newrel", 32'(cq[0]), 32'd7);
      check_eq("ld_second", 32'(tcq[1]), 32'd11);
    end
    stop_to_idle();

    // Asynchronous clear mid-count at cnt=4.
    bus.mode_i = 1'b0;
    load_val(6);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    cycle();
    cycle();
    check_eq("clr_pre", 32'(bus.cnt_o), 32'd4);
    #3;
    clr = 1'b1;
    model_reset();
    #1;
    check_eq("clr_cnt", 32'(bus.cnt_o), 32'd0);
    check_eq("clr_busy", 32'(bus.busy_o), 32'd0);
    check_eq("clr_tc", 32'(bus.tc_o), 32'd0);
    clr = 1'b0;
    cycle();
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    check_eq("clr_restart_cnt", 32'(bus.cnt_o), 32'd0);
    check_eq("clr_restart_busy", 32'(bus.busy_o), 32'd1);
    cycle();
    check_eq("clr_r0_tc", 32'(bus.tc_o), 32'd1);

`ifdef DOWNTIMER_TC_COUNT_EN
    // R=0 P=0 auto-reload saturates the tally.
    bus.mode_i = 1'b1;
    load_val(0);
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    for (int i = 0; i < 300; i++) cycle();
    check_eq("tcn_sat", 32'(bus.tc_cnt_o), 32'd255);
    stop_to_idle();
`endif

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      bus.load_i  = ($urandom_range(0, 99) < 8);
      bus.dat_i   = W'($urandom_range(0, 12));
      bus.start_i = ($urandom_range(0, 99) < 12);
      bus.stop_i  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 49) == 0) bus.mode_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) bus.pre_i = PW'($urandom_range(0, 3));
      clr = ($urandom_range(0, 499) == 0);
      cycle();
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
